// File: rtl/modulo_output_bcd.sv
// modulo_output_bcd
//   Output unit between the CPU datapath and the board displays/LEDs. A value handed over on the
//   OUT path (valid/ready) is converted binary->BCD one bit per cycle (shift-add-3). It is then
//   committed to DIGITS active-low 7-segment digits, with leading-zero blanking, an optional sign,
//   overflow dashes and HALT blanking. A registered LED bank also mirrors the switch-enable status.
//
// Ports
//   clk        system clock, all state on posedge
//   reset      synchronous, active-high
//   out_valid  value on out_data is available
//   out_data   value to display (two's complement when SIGNED)
//   out_ready  high while idle; a transfer happens on out_valid & out_ready
//   busy       conversion in progress (~out_ready)
//   done       one-cycle pulse when new digits commit
//   overflow   last committed value did not fit in DIGITS digits
//   halt       CPU halted: blank every digit (registered one cycle)
//   led_load   load led_data into the LED bank
//   led_data   LED payload
//   sw_enable  switch-enable status, mirrored on led[LED_W-1]
//   seg        digit i on seg[7i+6:7i] as {g,f,e,d,c,b,a}, active-low
//   led        registered LED outputs

module modulo_output_bcd #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned LED_W    = 14,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                out_valid,
  input  logic [DATA_W-1:0]   out_data,
  output logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  input  logic                halt,
  input  logic                led_load,
  input  logic [LED_W-2:0]    led_data,
  input  logic                sw_enable,
  output logic [7*DIGITS-1:0] seg,
  output logic [LED_W-1:0]    led
);

  localparam int unsigned BCD_DIGITS = (DATA_W * 301) / 1000 + 1;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 neg_conv_q;
  logic [4*DIGITS-1:0]  dig_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic                 done_q;
  logic                 halt_q;
  logic [LED_W-1:0]     led_q;

  logic [BCD_W-1:0]     bcd_adj;
  logic                 hi_nz;
  logic                 ovf_calc;
  logic [DIGITS-1:0]    show;
  logic [DIGITS-1:0]    sign_pos;
  logic                 any_nz;
  logic [7*DIGITS-1:0]  seg_digits;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

  // Shift-add-3 correction applied before every left shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Overflow: a significant digit beyond the display, or a negative value whose top displayed
  // digit is already in use so there is no room for the sign.
  always_comb begin
    hi_nz = 1'b0;
    for (int unsigned i = DIGITS; i < BCD_DIGITS; i++) begin
      hi_nz = hi_nz | (bcd_q[4*i +: 4] != 4'd0);
    end
    ovf_calc = hi_nz | (neg_conv_q & (bcd_q[4*(DIGITS-1) +: 4] != 4'd0));
  end

  // Control FSM and conversion datapath. A magnitude of -2^(DATA_W-1) still fits DATA_W bits
  // unsigned, so the negation below never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      neg_conv_q <= 1'b0;
      dig_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (out_valid) begin
            if (SIGNED && out_data[DATA_W-1]) begin
              bin_q      <= -out_data;
              neg_conv_q <= 1'b1;
            end else begin
              bin_q      <= out_data;
              neg_conv_q <= 1'b0;
            end
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= StConv;
          end
        end
        StConv: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          dig_q   <= bcd_q[4*DIGITS-1:0];
          neg_q   <= neg_conv_q;
          ovf_q   <= ovf_calc;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // HALT register and LED bank; reset takes priority over a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
      led_q  <= '0;
    end else begin
      halt_q           <= halt;
      led_q[LED_W-1]   <= sw_enable;
      if (led_load) begin
        led_q[LED_W-2:0] <= led_data;
      end
    end
  end

  // show[i]: digit i is at or below the most significant nonzero digit (digit 0 always shown).
  // sign_pos[i]: digit i sits just above the most significant shown digit.
  always_comb begin
    show     = '0;
    sign_pos = '0;
    any_nz   = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz  = any_nz | (dig_q[4*i +: 4] != 4'd0) | (i == 0);
      show[i] = any_nz;
    end
    for (int unsigned i = 1; i < DIGITS; i++) begin
      sign_pos[i] = show[i-1] & ~show[i];
    end
  end

  always_comb begin
    seg_digits = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (ovf_q) begin
        seg_digits[7*i +: 7] = SegDash;
      end else if (show[i]) begin
        seg_digits[7*i +: 7] = seg_decode(dig_q[4*i +: 4]);
      end else if (neg_q && sign_pos[i]) begin
        seg_digits[7*i +: 7] = SegDash;
      end else if (LZ_BLANK) begin
        seg_digits[7*i +: 7] = SegBlank;
      end else begin
        seg_digits[7*i +: 7] = seg_decode(4'd0);
      end
    end
    seg = halt_q ? '1 : seg_digits;
  end

  assign out_ready = (state_q == StIdle);
  assign busy      = ~out_ready;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign led       = led_q;

endmodule
